// File: rtl/char_plane_write_ctrl.sv
// Terminal-style write sequencer: turns a stream of character IDs into character-plane writes, scrolls and clears.
// Latency: printable/BS/NL one busy cycle after accept; a scroll adds 1 push_up cycle plus COL_NUMBER blank-fill cycles.
// Backpressure: in_ready is high only in IDLE; one ID is accepted per return to IDLE. Optional macro: CHAR_PLANE_AUTO_WRAP_EN.
module char_plane_write_ctrl #(
  parameter int ROW_NUMBER     = 15,
  parameter int COL_NUMBER     = 40,
  parameter int ROW_BIT_LEN    = 4,
  parameter int COL_BIT_LEN    = 6,
  parameter int CHAR_ID_LENGTH = 8,
  parameter logic [CHAR_ID_LENGTH-1:0] BLANK_ID = '0,
  parameter logic [CHAR_ID_LENGTH-1:0] NL_ID    = CHAR_ID_LENGTH'(8'h0A),
  parameter logic [CHAR_ID_LENGTH-1:0] BS_ID    = CHAR_ID_LENGTH'(8'h08),
  parameter logic [CHAR_ID_LENGTH-1:0] CLR_ID   = CHAR_ID_LENGTH'(8'h0C)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHAR_ID_LENGTH-1:0] in_char_id,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [ROW_BIT_LEN-1:0]    put_row,
  output logic [COL_BIT_LEN-1:0]    put_col,
  output logic [CHAR_ID_LENGTH-1:0] put_character_id,
  output logic                      we,
  output logic                      push_up,
  output logic                      plane_reset,
  output logic [ROW_BIT_LEN-1:0]    cursor_row,
  output logic [COL_BIT_LEN-1:0]    cursor_col,
  output logic                      busy
);

  localparam logic [ROW_BIT_LEN-1:0] ROW_LAST = ROW_BIT_LEN'(ROW_NUMBER - 1);
  localparam logic [COL_BIT_LEN-1:0] COL_LAST = COL_BIT_LEN'(COL_NUMBER - 1);
  localparam logic [ROW_BIT_LEN-1:0] ROW_ONE  = ROW_BIT_LEN'(1);
  localparam logic [COL_BIT_LEN-1:0] COL_ONE  = COL_BIT_LEN'(1);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_SCROLL, S_BLANK, S_CLEAR} state_e;

  state_e                    state_q;
  logic [ROW_BIT_LEN-1:0]    row_q;
  logic [COL_BIT_LEN-1:0]    col_q;
  logic [ROW_BIT_LEN-1:0]    put_row_q;
  logic [COL_BIT_LEN-1:0]    put_col_q;
  logic [CHAR_ID_LENGTH-1:0] put_id_q;
  logic                      we_q;
  logic                      push_up_q;
  logic                      plane_reset_q;
  logic                      busy_q;
  logic                      in_ready_q;
  // WRITE is also the one-cycle settle state for NL/BS; adv_q marks a printable write whose cursor must advance.
  logic                      adv_q;

  // Sequencer: state, cursor and every registered output move together so strobes stay mutually exclusive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      row_q         <= '0;
      col_q         <= '0;
      put_row_q     <= '0;
      put_col_q     <= '0;
      put_id_q      <= '0;
      we_q          <= 1'b0;
      push_up_q     <= 1'b0;
      plane_reset_q <= 1'b0;
      busy_q        <= 1'b0;
      in_ready_q    <= 1'b1;
      adv_q         <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            busy_q     <= 1'b1;
            in_ready_q <= 1'b0;
            adv_q      <= 1'b0;
            if (in_char_id == CLR_ID) begin
              state_q       <= S_CLEAR;
              plane_reset_q <= 1'b1;
              row_q         <= '0;
              col_q         <= '0;
            end else if (in_char_id == NL_ID) begin
              col_q <= '0;
              if (row_q < ROW_LAST) begin
                row_q   <= row_q + ROW_ONE;
                state_q <= S_WRITE;
              end else begin
                state_q   <= S_SCROLL;
                push_up_q <= 1'b1;
              end
            end else if (in_char_id == BS_ID) begin
              state_q <= S_WRITE;
              if (col_q != '0) begin
                col_q     <= col_q - COL_ONE;
                we_q      <= 1'b1;
                put_row_q <= row_q;
                put_col_q <= col_q - COL_ONE;
                put_id_q  <= BLANK_ID;
              end
            end else begin
              state_q   <= S_WRITE;
              adv_q     <= 1'b1;
              we_q      <= 1'b1;
              put_row_q <= row_q;
              put_col_q <= col_q;
              put_id_q  <= in_char_id;
            end
          end
        end

        S_WRITE: begin
          we_q  <= 1'b0;
          adv_q <= 1'b0;
          if (adv_q && (col_q == COL_LAST)) begin
`ifdef CHAR_PLANE_AUTO_WRAP_EN
            col_q <= '0;
            if (row_q < ROW_LAST) begin
              row_q      <= row_q + ROW_ONE;
              state_q    <= S_IDLE;
              busy_q     <= 1'b0;
              in_ready_q <= 1'b1;
            end else begin
              state_q   <= S_SCROLL;
              push_up_q <= 1'b1;
            end
`else
            // Without wrap the cursor parks on the last column until a newline.
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
`endif
          end else begin
            if (adv_q) col_q <= col_q + COL_ONE;
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
          end
        end

        S_SCROLL: begin
          push_up_q <= 1'b0;
          we_q      <= 1'b1;
          put_row_q <= ROW_LAST;
          put_col_q <= '0;
          put_id_q  <= BLANK_ID;
          state_q   <= S_BLANK;
        end

        S_BLANK: begin
          // put_col_q doubles as the blank-fill column counter.
          if (put_col_q == COL_LAST) begin
            we_q       <= 1'b0;
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
          end else begin
            put_col_q <= put_col_q + COL_ONE;
          end
        end

        S_CLEAR: begin
          plane_reset_q <= 1'b0;
          state_q       <= S_IDLE;
          busy_q        <= 1'b0;
          in_ready_q    <= 1'b1;
        end

        default: begin
          we_q          <= 1'b0;
          push_up_q     <= 1'b0;
          plane_reset_q <= 1'b0;
          state_q       <= S_IDLE;
          busy_q        <= 1'b0;
          in_ready_q    <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready         = in_ready_q;
  assign put_row          = put_row_q;
  assign put_col          = put_col_q;
  assign put_character_id = put_id_q;
  assign we               = we_q;
  assign push_up          = push_up_q;
  assign plane_reset      = plane_reset_q;
  assign cursor_row       = row_q;
  assign cursor_col       = col_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_char_plane_write_ctrl.sv
// Bench for char_plane_write_ctrl: directed scenarios plus random IDs against a cursor/event reference model.
module tb_char_plane_write_ctrl;

  localparam int ROWS = 15;
  localparam int COLS = 40;
  localparam logic [7:0] NL  = 8'h0A;
  localparam logic [7:0] BS  = 8'h08;
  localparam logic [7:0] CLR = 8'h0C;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in_char_id;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] put_row;
  logic [5:0] put_col;
  logic [7:0] put_character_id;
  logic       we, push_up, plane_reset, busy;
  logic [3:0] cursor_row;
  logic [5:0] cursor_col;

  char_plane_write_ctrl dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .in_char_id       (in_char_id),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .put_row          (put_row),
    .put_col          (put_col),
    .put_character_id (put_character_id),
    .we               (we),
    .push_up          (push_up),
    .plane_reset      (plane_reset),
    .cursor_row       (cursor_row),
    .cursor_col       (cursor_col),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  // One expected busy cycle after an accept.
  typedef struct packed {
    logic       we;
    logic       pu;
    logic       pr;
    logic [3:0] row;
    logic [5:0] col;
    logic [7:0] id;
  } cyc_t;

  cyc_t exp_q[$];
  int   m_row, m_col;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_cyc(input logic w, input logic pu, input logic pr,
                         input int r, input int c, input logic [7:0] id);
    cyc_t e;
    e.we = w; e.pu = pu; e.pr = pr;
    e.row = 4'(r); e.col = 6'(c); e.id = id;
    exp_q.push_back(e);
  endtask

  task automatic add_scroll();
    add_cyc(1'b0, 1'b1, 1'b0, 0, 0, 8'h00);
    for (int c = 0; c < COLS; c++) add_cyc(1'b1, 1'b0, 1'b0, ROWS - 1, c, 8'h00);
  endtask

  // Terminal semantics: what the plane should see for one character, and where the cursor ends up.
  task automatic model(input logic [7:0] id);
    exp_q.delete();
    if (id == CLR) begin
      add_cyc(1'b0, 1'b0, 1'b1, 0, 0, 8'h00);
      m_row = 0; m_col = 0;
    end else if (id == NL) begin
      m_col = 0;
      if (m_row < ROWS - 1) begin
        m_row++;
        add_cyc(1'b0, 1'b0, 1'b0, 0, 0, 8'h00);
      end else begin
        add_scroll();
      end
    end else if (id == BS) begin
      if (m_col > 0) begin
        m_col--;
        add_cyc(1'b1, 1'b0, 1'b0, m_row, m_col, 8'h00);
      end else begin
        add_cyc(1'b0, 1'b0, 1'b0, 0, 0, 8'h00);
      end
    end else begin
      add_cyc(1'b1, 1'b0, 1'b0, m_row, m_col, id);
      if (m_col < COLS - 1) begin
        m_col++;
      end else begin
`ifdef CHAR_PLANE_AUTO_WRAP_EN
        m_col = 0;
        if (m_row < ROWS - 1) m_row++;
        else add_scroll();
`endif
      end
    end
  endtask

  // Called #1 after a clock edge with in_ready expected high; returns at the same phase with the DUT idle again.
  task automatic send(input logic [7:0] id);
    model(id);
    chk("ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_char_id = id;
    in_valid   = 1'b1;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("we", {31'd0, we}, {31'd0, exp_q[k].we});
      chk("push_up", {31'd0, push_up}, {31'd0, exp_q[k].pu});
      chk("plane_reset", {31'd0, plane_reset}, {31'd0, exp_q[k].pr});
      chk("busy_ready_during", {30'd0, busy, in_ready}, 32'b10);
      if (exp_q[k].we)
        chk("put_row_col_id", {14'd0, put_row, put_col, put_character_id},
            {14'd0, exp_q[k].row, exp_q[k].col, exp_q[k].id});
    end
    @(posedge clk); #1;
    chk("ready_after", {30'd0, busy, in_ready}, 32'b01);
    chk("strobes_idle", {29'd0, we, push_up, plane_reset}, 32'd0);
    chk("cursor", {22'd0, cursor_row, cursor_col}, {22'd0, 4'(m_row), 6'(m_col)});
  endtask

  task automatic chk_reset(input string tag);
    chk(tag, {29'd0, we, push_up, plane_reset}, 32'd0);
    chk("reset_ready_busy", {30'd0, busy, in_ready}, 32'b01);
    chk("reset_put", {14'd0, put_row, put_col, put_character_id}, 32'd0);
    chk("reset_cursor", {22'd0, cursor_row, cursor_col}, 32'd0);
  endtask

  initial begin
    logic [7:0] r;
    logic       found;
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_char_id = 8'h00;
    m_row = 0; m_col = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset_strobes");
    reset_n = 1'b1;
    @(posedge clk); #1;

    // First printable character lands at the origin.
    send(8'h41);
    chk("A_cursor", {22'd0, cursor_row, cursor_col}, {22'd0, 4'd0, 6'd1});

    // Row fill: 41 writes starting at column 0.
    send(CLR);
    for (int i = 0; i < 41; i++) send(8'h41);
`ifdef CHAR_PLANE_AUTO_WRAP_EN
    chk("fill_cursor", {22'd0, cursor_row, cursor_col}, {22'd0, 4'd1, 6'd1});
`else
    chk("fill_cursor", {22'd0, cursor_row, cursor_col}, {22'd0, 4'd0, 6'd39});
`endif

    // Scroll from (14,5) on newline.
    send(CLR);
    for (int i = 0; i < 14; i++) send(NL);
    for (int i = 0; i < 5; i++) send(8'h42);
    send(NL);
    chk("scroll_cursor", {22'd0, cursor_row, cursor_col}, {22'd0, 4'd14, 6'd0});

    // Backspace at column 0 and in the middle of a row.
    send(CLR);
    for (int i = 0; i < 3; i++) send(NL);
    send(BS);
    chk("bs_col0_cursor", {22'd0, cursor_row, cursor_col}, {22'd0, 4'd3, 6'd0});
    for (int i = 0; i < 7; i++) send(8'h43);
    send(BS);
    chk("bs_col7_cursor", {22'd0, cursor_row, cursor_col}, {22'd0, 4'd3, 6'd6});

    // Random traffic, weighted toward control codes so scrolls and wraps occur.
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 19))
        0, 1, 2, 3, 4: r = NL;
        5, 6:          r = BS;
        7:             r = CLR;
        default:       r = 8'($urandom_range(0, 255));
      endcase
      send(r);
    end

    // Asynchronous reset in the middle of the blank fill.
    send(CLR);
    for (int i = 0; i < 14; i++) send(NL);
    in_char_id = NL;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("abort_push_up", {31'd0, push_up}, 32'd1);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk); #1;
      if (we && put_col == 6'd20) found = 1'b1;
    end
    chk("abort_reached_col20", {31'd0, found}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk_reset("abort_strobes");
    #1 reset_n = 1'b1;
    m_row = 0; m_col = 0;
    @(posedge clk); #1;
    chk_reset("post_abort_idle");
    send(8'h5A);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
